// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: opcodes, default widths, station entry.
package tomasulo_pkg;

  localparam int TAG_W  = 3;
  localparam int DATA_W = 16;
  localparam int FUNC_W = 4;
  localparam int AGE_W  = 4;

  localparam logic [FUNC_W-1:0] OP_ADD = 4'b0000;
  localparam logic [FUNC_W-1:0] OP_SUB = 4'b0001;
  localparam logic [FUNC_W-1:0] OP_MUL = 4'b0010;
  localparam logic [FUNC_W-1:0] OP_DIV = 4'b0011;

  typedef struct packed {
    logic              busy;
    logic [FUNC_W-1:0] func;
    logic [TAG_W-1:0]  dest;
    logic              j_rdy;
    logic [DATA_W-1:0] vj;
    logic [TAG_W-1:0]  qj;
    logic              k_rdy;
    logic [DATA_W-1:0] vk;
    logic [TAG_W-1:0]  qk;
    logic [AGE_W-1:0]  age;
  } rs_entry_t;

endpackage

// File: rtl/rs_age_select.sv
// Oldest-ready picker: max age wins, ties go to the lowest index.
module rs_age_select #(
  parameter int DEPTH = 2,
  parameter int AGE_W = 4
) (
  input  logic [DEPTH-1:0]            ready,
  input  logic [DEPTH-1:0][AGE_W-1:0] age,
  output logic [DEPTH-1:0]            grant,
  output logic                        valid
);

  logic [AGE_W-1:0] best;

  always_comb begin
    grant = '0;
    best  = '0;
    valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ready[i] && (!valid || age[i] > best)) begin
        grant    = '0;
        grant[i] = 1'b1;
        best     = age[i];
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rstation_slot_array.sv
// Reservation-station bank with CDB wakeup and oldest-first dispatch.
// Define RS_ISSUE_BYPASS_EN to capture a same-cycle CDB hit at allocate.
module rstation_slot_array
  import tomasulo_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int TAG_W  = tomasulo_pkg::TAG_W,
  parameter int DATA_W = tomasulo_pkg::DATA_W,
  parameter int FUNC_W = tomasulo_pkg::FUNC_W,
  parameter int AGE_W  = tomasulo_pkg::AGE_W,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              iss_valid,
  output logic              iss_ready,
  input  logic [FUNC_W-1:0] iss_func,
  input  logic [TAG_W-1:0]  iss_dest,
  input  logic              iss_j_rdy,
  input  logic              iss_k_rdy,
  input  logic [DATA_W-1:0] iss_vj,
  input  logic [DATA_W-1:0] iss_vk,
  input  logic [TAG_W-1:0]  iss_qj,
  input  logic [TAG_W-1:0]  iss_qk,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              disp_valid,
  input  logic              fu_ready,
  output logic [FUNC_W-1:0] disp_func,
  output logic [TAG_W-1:0]  disp_dest,
  output logic [DATA_W-1:0] disp_vj,
  output logic [DATA_W-1:0] disp_vk,
  output logic [CNT_W-1:0]  free_cnt
);

  typedef struct packed {
    logic              busy;
    logic [FUNC_W-1:0] func;
    logic [TAG_W-1:0]  dest;
    logic              j_rdy;
    logic [DATA_W-1:0] vj;
    logic [TAG_W-1:0]  qj;
    logic              k_rdy;
    logic [DATA_W-1:0] vk;
    logic [TAG_W-1:0]  qk;
    logic [AGE_W-1:0]  age;
  } slot_t;

  slot_t rs_q [DEPTH];
  slot_t rs_d [DEPTH];
  slot_t new_slot;

  logic [DEPTH-1:0]            busy;
  logic [DEPTH-1:0]            rdy;
  logic [DEPTH-1:0][AGE_W-1:0] ages;
  logic [DEPTH-1:0]            pick;
  logic [DEPTH-1:0]            grant;
  logic [DEPTH-1:0]            freed;
  logic [DEPTH-1:0]            avail;
  logic [DEPTH-1:0]            alloc_oh;
  logic [DEPTH-1:0]            lock_oh_q;
  logic                        lock_q;
  logic                        any_rdy;
  logic                        fire;
  logic                        alloc;
  logic [CNT_W-1:0]            n_busy;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      busy[i] = rs_q[i].busy;
      rdy[i]  = rs_q[i].busy & rs_q[i].j_rdy & rs_q[i].k_rdy;
      ages[i] = rs_q[i].age;
    end
  end

  rs_age_select #(
    .DEPTH (DEPTH),
    .AGE_W (AGE_W)
  ) u_sel (
    .ready (rdy),
    .age   (ages),
    .grant (pick),
    .valid (any_rdy)
  );

  // A stalled dispatch keeps its choice so the FU sees stable data.
  assign grant      = lock_q ? lock_oh_q : pick;
  assign disp_valid = any_rdy;
  assign fire       = disp_valid & fu_ready;
  assign freed      = fire ? grant : '0;
  assign avail      = ~busy | freed;
  assign alloc_oh   = avail & (~avail + DEPTH'(1));
  assign iss_ready  = |avail;
  assign alloc      = iss_valid & iss_ready & ~flush;

  always_comb begin
    disp_func = '0;
    disp_dest = '0;
    disp_vj   = '0;
    disp_vk   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) begin
        disp_func = disp_func | rs_q[i].func;
        disp_dest = disp_dest | rs_q[i].dest;
        disp_vj   = disp_vj | rs_q[i].vj;
        disp_vk   = disp_vk | rs_q[i].vk;
      end
    end
  end

  always_comb begin
    n_busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      n_busy = n_busy + CNT_W'(busy[i]);
    end
    free_cnt = CNT_W'(DEPTH) - n_busy;
  end

  always_comb begin
    new_slot       = '0;
    new_slot.busy  = 1'b1;
    new_slot.func  = iss_func;
    new_slot.dest  = iss_dest;
    new_slot.j_rdy = iss_j_rdy;
    new_slot.vj    = iss_vj;
    new_slot.qj    = iss_qj;
    new_slot.k_rdy = iss_k_rdy;
    new_slot.vk    = iss_vk;
    new_slot.qk    = iss_qk;
`ifdef RS_ISSUE_BYPASS_EN
    if (!iss_j_rdy && cdb_valid && cdb_tag == iss_qj) begin
      new_slot.j_rdy = 1'b1;
      new_slot.vj    = cdb_data;
    end
    if (!iss_k_rdy && cdb_valid && cdb_tag == iss_qk) begin
      new_slot.k_rdy = 1'b1;
      new_slot.vk    = cdb_data;
    end
`endif
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      rs_d[i] = rs_q[i];
      if (rs_q[i].busy) begin
        if (!rs_q[i].j_rdy && cdb_valid && cdb_tag == rs_q[i].qj) begin
          rs_d[i].j_rdy = 1'b1;
          rs_d[i].vj    = cdb_data;
        end
        if (!rs_q[i].k_rdy && cdb_valid && cdb_tag == rs_q[i].qk) begin
          rs_d[i].k_rdy = 1'b1;
          rs_d[i].vk    = cdb_data;
        end
        if (rs_q[i].age != '1) begin
          rs_d[i].age = rs_q[i].age + 1'b1;
        end
      end
      if (freed[i]) begin
        rs_d[i].busy = 1'b0;
      end
      if (alloc && alloc_oh[i]) begin
        rs_d[i] = new_slot;
      end
      if (flush) begin
        rs_d[i].busy = 1'b0;
      end
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        rs_q[i] <= '0;
      end
      lock_q    <= 1'b0;
      lock_oh_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        rs_q[i] <= rs_d[i];
      end
      lock_q    <= disp_valid & ~fu_ready & ~flush;
      lock_oh_q <= grant;
    end
  end

endmodule

// File: tb/tb_rstation_slot_array.sv
// Directed plus random checks of the station against a slot-level model.
module tb_rstation_slot_array;
  import tomasulo_pkg::*;

  localparam int DEPTH = 2;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic        clk1 = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        iss_valid = 1'b0;
  logic        iss_ready;
  logic [3:0]  iss_func = '0;
  logic [2:0]  iss_dest = '0;
  logic        iss_j_rdy = 1'b0;
  logic        iss_k_rdy = 1'b0;
  logic [15:0] iss_vj = '0;
  logic [15:0] iss_vk = '0;
  logic [2:0]  iss_qj = '0;
  logic [2:0]  iss_qk = '0;
  logic        cdb_valid = 1'b0;
  logic [2:0]  cdb_tag = '0;
  logic [15:0] cdb_data = '0;
  logic        disp_valid;
  logic        fu_ready = 1'b0;
  logic [3:0]  disp_func;
  logic [2:0]  disp_dest;
  logic [15:0] disp_vj;
  logic [15:0] disp_vk;
  logic [CNT_W-1:0] free_cnt;

  always #5 clk1 = ~clk1;

  rstation_slot_array #(.DEPTH(DEPTH)) dut (
    .clk1       (clk1),
    .rst_n      (rst_n),
    .flush      (flush),
    .iss_valid  (iss_valid),
    .iss_ready  (iss_ready),
    .iss_func   (iss_func),
    .iss_dest   (iss_dest),
    .iss_j_rdy  (iss_j_rdy),
    .iss_k_rdy  (iss_k_rdy),
    .iss_vj     (iss_vj),
    .iss_vk     (iss_vk),
    .iss_qj     (iss_qj),
    .iss_qk     (iss_qk),
    .cdb_valid  (cdb_valid),
    .cdb_tag    (cdb_tag),
    .cdb_data   (cdb_data),
    .disp_valid (disp_valid),
    .fu_ready   (fu_ready),
    .disp_func  (disp_func),
    .disp_dest  (disp_dest),
    .disp_vj    (disp_vj),
    .disp_vk    (disp_vk),
    .free_cnt   (free_cnt)
  );

  typedef struct {
    bit          busy;
    logic [3:0]  func;
    logic [2:0]  dest;
    bit          jr;
    bit          kr;
    logic [15:0] vj;
    logic [15:0] vk;
    logic [2:0]  qj;
    logic [2:0]  qk;
    int          t;
  } m_t;

  m_t m [DEPTH];
  int cyc;
  bit hold;
  int hold_idx;
  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int age_of(int i);
    int a;
    a = cyc - m[i].t;
    return (a > 15) ? 15 : a;
  endfunction

  function automatic int pick();
    int best;
    best = -1;
    if (hold) return hold_idx;
    for (int i = 0; i < DEPTH; i++) begin
      if (m[i].busy && m[i].jr && m[i].kr &&
          (best < 0 || age_of(i) > age_of(best))) best = i;
    end
    return best;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m[i] = '{default: 0};
    end
    cyc = 0;
    hold = 0;
    hold_idx = 0;
  endtask

  task automatic idle();
    iss_valid = 1'b0;
    cdb_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic issue(input logic [3:0] f, input logic [2:0] d,
                       input bit jr, input logic [15:0] vj,
                       input logic [2:0] qj, input bit kr,
                       input logic [15:0] vk, input logic [2:0] qk);
    iss_valid = 1'b1;
    iss_func = f;
    iss_dest = d;
    iss_j_rdy = jr;
    iss_vj = vj;
    iss_qj = qj;
    iss_k_rdy = kr;
    iss_vk = vk;
    iss_qk = qk;
  endtask

  // One clock: check outputs against the model, then advance it.
  task automatic step();
    int s;
    int fr;
    int idx;
    bit rdy;
    bit nh;
    m_t nx [DEPTH];
    #1;
    s = pick();
    fr = 0;
    for (int i = 0; i < DEPTH; i++) if (!m[i].busy) fr++;
    rdy = (fr != 0) || (s >= 0 && fu_ready);
    chk("disp_valid", 32'(disp_valid), 32'(s >= 0));
    if (s >= 0) begin
      chk("disp_dest", 32'(disp_dest), 32'(m[s].dest));
      chk("disp_func", 32'(disp_func), 32'(m[s].func));
      chk("disp_vj", 32'(disp_vj), 32'(m[s].vj));
      chk("disp_vk", 32'(disp_vk), 32'(m[s].vk));
    end else begin
      chk("idle_dest", 32'(disp_dest), 32'd0);
      chk("idle_vj", 32'(disp_vj), 32'd0);
    end
    chk("iss_ready", 32'(iss_ready), 32'(rdy));
    chk("free_cnt", 32'(free_cnt), 32'(fr));
    nx = m;
    nh = 0;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) nx[i].busy = 0;
    end else begin
      nh = (s >= 0) && !fu_ready;
      for (int i = 0; i < DEPTH; i++) begin
        if (m[i].busy && cdb_valid) begin
          if (!m[i].jr && m[i].qj == cdb_tag) begin
            nx[i].jr = 1; nx[i].vj = cdb_data;
          end
          if (!m[i].kr && m[i].qk == cdb_tag) begin
            nx[i].kr = 1; nx[i].vk = cdb_data;
          end
        end
      end
      if (s >= 0 && fu_ready) nx[s].busy = 0;
      if (iss_valid && rdy) begin
        idx = -1;
        for (int i = DEPTH - 1; i >= 0; i--) if (!nx[i].busy) idx = i;
        nx[idx] = '{busy: 1, func: iss_func, dest: iss_dest,
                    jr: iss_j_rdy, kr: iss_k_rdy, vj: iss_vj,
                    vk: iss_vk, qj: iss_qj, qk: iss_qk, t: cyc + 1};
`ifdef RS_ISSUE_BYPASS_EN
        if (!iss_j_rdy && cdb_valid && cdb_tag == iss_qj) begin
          nx[idx].jr = 1; nx[idx].vj = cdb_data;
        end
        if (!iss_k_rdy && cdb_valid && cdb_tag == iss_qk) begin
          nx[idx].kr = 1; nx[idx].vk = cdb_data;
        end
`endif
      end
    end
    @(posedge clk1);
    m = nx;
    cyc++;
    hold = nh;
    hold_idx = s;
    @(negedge clk1);
  endtask

  initial begin
    model_reset();
    #2;
    chk("rst_disp_valid", 32'(disp_valid), 32'd0);
    chk("rst_iss_ready", 32'(iss_ready), 32'd1);
    chk("rst_free_cnt", 32'(free_cnt), 32'(DEPTH));
    chk("rst_disp_vk", 32'(disp_vk), 32'd0);
    @(negedge clk1);
    rst_n = 1'b1;

    // ready ADD dispatches next cycle
    fu_ready = 1'b1;
    issue(OP_ADD, 3'd3, 1, 16'd5, 3'd0, 1, 16'd7, 3'd0);
    step();
    idle();
    #1;
    chk("t1_valid", 32'(disp_valid), 32'd1);
    chk("t1_dest", 32'(disp_dest), 32'd3);
    chk("t1_vj", 32'(disp_vj), 32'd5);
    chk("t1_vk", 32'(disp_vk), 32'd7);
    step();
    #1;
    chk("t1_free", 32'(free_cnt), 32'd2);

    // operand j waits for CDB tag 4
    issue(OP_SUB, 3'd1, 0, 16'd0, 3'd4, 1, 16'd2, 3'd0);
    step();
    idle();
    #1;
    chk("t2_wait", 32'(disp_valid), 32'd0);
    step();
    cdb_valid = 1'b1;
    cdb_tag = 3'd4;
    cdb_data = 16'h00A0;
    step();
    idle();
    #1;
    chk("t2_valid", 32'(disp_valid), 32'd1);
    chk("t2_vj", 32'(disp_vj), 32'h00A0);
    chk("t2_vk", 32'(disp_vk), 32'd2);
    step();

    // fill, stall, then dispatch+allocate in one cycle
    fu_ready = 1'b0;
    issue(OP_MUL, 3'd2, 1, 16'd11, 3'd0, 1, 16'd12, 3'd0);
    step();
    issue(OP_DIV, 3'd5, 1, 16'd13, 3'd0, 1, 16'd14, 3'd0);
    step();
    idle();
    #1;
    chk("t3_ready0", 32'(iss_ready), 32'd0);
    chk("t3_free0", 32'(free_cnt), 32'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4_hold_dest", 32'(disp_dest), 32'd2);
      chk("t4_hold_vj", 32'(disp_vj), 32'd11);
      step();
    end
    fu_ready = 1'b1;
    issue(OP_ADD, 3'd6, 1, 16'd15, 3'd0, 1, 16'd16, 3'd0);
    #1;
    chk("t3_ready1", 32'(iss_ready), 32'd1);
    step();
    idle();
    #1;
    chk("t3_free_kept", 32'(free_cnt), 32'd0);
    chk("t4_older", 32'(disp_dest), 32'd5);

    // flush beats a simultaneous issue
    fu_ready = 1'b0;
    flush = 1'b1;
    issue(OP_SUB, 3'd7, 1, 16'd1, 3'd0, 1, 16'd1, 3'd0);
    step();
    idle();
    #1;
    chk("t5_free", 32'(free_cnt), 32'(DEPTH));
    chk("t5_valid", 32'(disp_valid), 32'd0);
    step();

    // issue racing a CDB broadcast of its own producer tag
    fu_ready = 1'b1;
    issue(OP_ADD, 3'd0, 0, 16'd0, 3'd6, 1, 16'd1, 3'd0);
    cdb_valid = 1'b1;
    cdb_tag = 3'd6;
    cdb_data = 16'd9;
    step();
    idle();
    #1;
`ifdef RS_ISSUE_BYPASS_EN
    chk("t6_bypass_valid", 32'(disp_valid), 32'd1);
    chk("t6_bypass_vj", 32'(disp_vj), 32'd9);
`else
    chk("t6_missed", 32'(disp_valid), 32'd0);
`endif
    cdb_valid = 1'b1;
    cdb_tag = 3'd6;
    cdb_data = 16'd9;
    step();
    idle();
    step();
    step();

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      iss_valid = 1'($urandom_range(0, 1));
      iss_func = 4'($urandom_range(0, 3));
      iss_dest = 3'($urandom);
      iss_j_rdy = 1'($urandom_range(0, 1));
      iss_k_rdy = 1'($urandom_range(0, 1));
      iss_vj = 16'($urandom);
      iss_vk = 16'($urandom);
      iss_qj = 3'($urandom);
      iss_qk = 3'($urandom);
      cdb_valid = ($urandom_range(0, 2) != 0);
      cdb_tag = 3'($urandom);
      cdb_data = 16'($urandom);
      fu_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 31) == 0);
      step();
    end

    // asynchronous reset in mid-operation
    idle();
    fu_ready = 1'b0;
    issue(OP_MUL, 3'd4, 0, 16'd0, 3'd1, 0, 16'd0, 3'd2);
    step();
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_free", 32'(free_cnt), 32'(DEPTH));
    chk("arst_valid", 32'(disp_valid), 32'd0);
    chk("arst_ready", 32'(iss_ready), 32'd1);
    @(negedge clk1);
    rst_n = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rstation_slot_array.md
Name: rstation_slot_array

Overview:
- Reservation-station bank directly downstream of the issue stage in the Tomasulo core.
- Accepts one issued instruction per cycle, holding opcode, destination ROB tag and two operands as value or producer tag.
- Snoops the common data bus (CDB) to wake waiting operands.
- Dispatches the oldest fully-ready entry to its functional unit; free-slot count replaces the issue stage's add/mul occupancy counters.

Parameters:
- DEPTH, 2, number of station entries (2..8)
- TAG_W, 3, ROB tag width (8-entry ROB)
- DATA_W, 16, operand/result width
- FUNC_W, 4, opcode width
- AGE_W, 4, saturating age counter width

Ports:
- clk1  in  1  pipeline clock; all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of all entries (mispredict)
- iss_valid  in  1  issue stage presents an instruction
- iss_ready  out  1  at least one free entry
- iss_func  in  FUNC_W  opcode
- iss_dest  in  TAG_W  destination ROB index
- iss_j_rdy / iss_k_rdy  in  1  operand j/k already a value
- iss_vj / iss_vk  in  DATA_W  operand values (valid when *_rdy)
- iss_qj / iss_qk  in  TAG_W  producer tags (valid when !*_rdy)
- cdb_valid  in  1  CDB broadcast this cycle
- cdb_tag  in  TAG_W  broadcasting ROB tag
- cdb_data  in  DATA_W  broadcast value
- disp_valid  out  1  dispatch request to FU
- fu_ready  in  1  FU accepts
- disp_func / disp_dest  out  FUNC_W / TAG_W  dispatched op, dest tag
- disp_vj / disp_vk  out  DATA_W  dispatched operands
- free_cnt  out  $clog2(DEPTH+1)  number of free entries

Behaviour:
- Reset (rst_n low, async): all entries not busy; disp_valid=0; iss_ready=1; free_cnt=DEPTH; disp_* data outputs=0. Reset mid-operation drops all held instructions.
- Entry state: busy, func, dest, j_rdy, vj, qj, k_rdy, vk, qk, age.
- Allocate: on iss_valid & iss_ready, write lowest-index free entry with age=0. iss_ready is combinational = (free_cnt != 0), including same-cycle frees.
- Wakeup: each cycle, for every busy entry with !j_rdy and cdb_valid & cdb_tag==qj, set vj=cdb_data, j_rdy=1; same for k. Both operands may wake on one broadcast.
- Ready: busy & j_rdy & k_rdy, as registered state. An entry woken at edge N is dispatchable from cycle N+1. Minimum issue-to-dispatch latency is 1 cycle.
- Select: among ready entries, pick max age; ties go to lowest index. disp_* are combinational from the selected entry. disp_valid = any ready.
- Dispatch: on disp_valid & fu_ready, clear the selected entry's busy. disp_* must hold stable while disp_valid & !fu_ready, unless a flush occurs.
- Age: each clock, every busy entry not allocated this cycle increments age, saturating at 2^AGE_W-1.
- Simultaneous dispatch and allocate: legal. A freed slot may be reallocated in the same cycle, with iss_ready=1 even when full before the dispatch.
- Simultaneous issue and CDB matching an issued tag: see optional feature. Without it, the issue stage must not present a tag already broadcast.
- flush: clears all busy at the edge. Takes priority over allocate and dispatch. disp_valid=0 the following cycle.
- free_cnt = DEPTH - popcount(busy), registered.

Optional Feature:
- RS_ISSUE_BYPASS_EN defined: at allocate, if cdb_valid and cdb_tag equals iss_qj (with !iss_j_rdy), store cdb_data and set j_rdy=1. Same for k. This closes the issue/writeback race.
- Not defined: the operand is stored as a tag and waits for a later broadcast. The same-cycle broadcast is missed.

Decomposition:
- Package tomasulo_pkg: opcode constants OP_ADD=4'b0000, OP_SUB=4'b0001, OP_MUL=4'b0010, OP_DIV=4'b0011; TAG_W, DATA_W, FUNC_W defaults; rs_entry_t struct.
- Sub-module rs_age_select: a combinational oldest-ready picker, taking per-entry ready and age vectors and returning a one-hot grant and a valid.

Test Plan:
- Reset then issue ADD dest=3, vj=5, vk=7 both ready, fu_ready=1 -> disp_valid next cycle with dest=3, vj=5, vk=7; free_cnt returns to 2 after dispatch.
- Issue dest=1 with qj=4 (not ready), vk=2 -> no dispatch; CDB tag=4 data=0x00A0 -> disp_valid the next cycle with vj=0x00A0, vk=2.
- DEPTH=2 full, fu_ready=0 -> iss_ready=0, free_cnt=0. Raise fu_ready with iss_valid high -> one dispatch and one allocate in the same cycle; free_cnt stays 0.
- Two ready entries, older dest=2 and younger dest=5 -> dest=2 dispatched first. Hold fu_ready=0 for 3 cycles -> disp_* stable on dest=2.
- Busy entries with flush=1 and simultaneous iss_valid -> all entries cleared, nothing allocated, free_cnt=DEPTH, disp_valid=0.
- Issue qj=6 with cdb_valid, tag=6, data=9 in the same cycle:
  - with RS_ISSUE_BYPASS_EN -> dispatch next cycle with vj=9;
  - without it -> entry stays waiting.
